load_miss_buffer: RTL

Parametrised load-completion buffer between the load functional unit, the data cache MSHR fill path and the CDB. It holds loads whose bytes are still outstanding in cache MSHRs and merges fill data from up to `FILL_PORTS` simultaneous cache returns. It selects the oldest fully-resolved load internally, then formats, sign- or zero-extends and presents it for CDB broadcast. Branch-mask tracking squashes or updates entries on branch resolution.

---
 rtl/load_miss_buffer.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/load_miss_buffer.sv
// Load completion buffer: parks loads waiting on MSHR fills, merges fill bytes,
// tracks branch masks and presents the oldest fully-resolved load to the CDB.
module load_miss_buffer #(
  parameter int DEPTH      = 8,
  parameter int FILL_PORTS = 2,
  parameter int LINE_WORDS = 2,
  parameter int BM_W       = 4,
  parameter int PREG_W     = 6,
  parameter int MSHR_W     = 3
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [PREG_W-1:0]                   in_dest,
  input  logic [BM_W-1:0]                     in_bm,
  input  logic [MSHR_W-1:0]                   in_mshr,
  input  logic [$clog2(LINE_WORDS)+1:0]       in_addr,
  input  logic [2:0]                          in_func,
  input  logic [3:0]                          in_byte_mask,
  input  logic [31:0]                         in_data,
  input  logic [FILL_PORTS-1:0]               fill_valid,
  input  logic [FILL_PORTS*MSHR_W-1:0]        fill_mshr,
  input  logic [FILL_PORTS*LINE_WORDS*32-1:0] fill_data,
  input  logic [BM_W-1:0]                     br_resolve,
  input  logic                                br_mispred,
  output logic                                cdb_req,
  input  logic                                cdb_gnt,
  output logic [PREG_W-1:0]                   cdb_dest,
  output logic [31:0]                         cdb_data,
  output logic [$clog2(DEPTH):0]              count
);

  localparam int AW = $clog2(LINE_WORDS) + 2;
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  // Merge matching fill ports into the pending bytes; lower ports override higher ones.
  function automatic logic [35:0] merge_fill(
    input logic [MSHR_W-1:0]                   mshr,
    input logic [AW-1:0]                       addr,
    input logic [3:0]                          pend,
    input logic [31:0]                         data,
    input logic [FILL_PORTS-1:0]               fv,
    input logic [FILL_PORTS*MSHR_W-1:0]        fm,
    input logic [FILL_PORTS*LINE_WORDS*32-1:0] fd
  );
    logic [3:0]  p_out;
    logic [31:0] d_out;
    int          w;
    p_out = pend;
    d_out = data;
    w     = int'(addr >> 2);
    for (int p = FILL_PORTS - 1; p >= 0; p--) begin
      if (fv[p] && (fm[p*MSHR_W +: MSHR_W] == mshr)) begin
        for (int j = 0; j < 4; j++) begin
          if (pend[j]) begin
            d_out[j*8 +: 8] = fd[(p*LINE_WORDS + w)*32 + j*8 +: 8];
            p_out[j]        = 1'b0;
          end else begin
            d_out[j*8 +: 8] = d_out[j*8 +: 8];
          end
        end
      end else begin
        p_out = p_out;
      end
    end
    return {p_out, d_out};
  endfunction

  // Align the addressed bytes to bit 0 and extend according to size/signedness.
  function automatic logic [31:0] format_result(
    input logic [31:0] data,
    input logic [1:0]  off,
    input logic [2:0]  func
  );
    logic [31:0] sh;
    logic [31:0] res;
    sh = data >> {off, 3'b000};
    case (func[1:0])
      2'd0:    res = func[2] ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'd1:    res = func[2] ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  logic [DEPTH-1:0]   valid_r;
  logic [PREG_W-1:0]  dest_r  [DEPTH];
  logic [BM_W-1:0]    bm_r    [DEPTH];
  logic [MSHR_W-1:0]  mshr_r  [DEPTH];
  logic [AW-1:0]      addr_r  [DEPTH];
  logic [2:0]         func_r  [DEPTH];
  logic [3:0]         pend_r  [DEPTH];
  logic [31:0]        data_r  [DEPTH];
  logic [DEPTH-1:0]   older_r [DEPTH];   // older_r[j][i]: entry j was allocated before entry i
  logic [CW-1:0]      count_r;

  logic [DEPTH-1:0]   ready_s;
  logic [DEPTH-1:0]   blocked_s;
  logic [DEPTH-1:0]   squash_s;
  logic [DEPTH-1:0]   valid_nxt_s;
  logic [3:0]         mrg_pend_s [DEPTH];
  logic [31:0]        mrg_data_s [DEPTH];
  logic [3:0]         in_pend_s;
  logic [31:0]        in_data_s;
  logic               sel_valid_s;
  logic [IW-1:0]      sel_idx_s;
  logic [IW-1:0]      free_idx_s;
  logic               in_ready_s;
  logic               alloc_s;
  logic               gnt_s;
  logic [CW-1:0]      cnt_nxt_s;

  assign in_ready_s = (count_r != CW'(DEPTH));
  assign in_ready   = in_ready_s;
  assign count      = count_r;
  assign alloc_s    = in_valid && in_ready_s && !(br_mispred && (|(in_bm & br_resolve)));
  assign gnt_s      = cdb_gnt && sel_valid_s;

  // Readiness, squash detection and "an older ready entry exists" per entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ready_s[i]   = valid_r[i] && (pend_r[i] == 4'd0);
      squash_s[i]  = br_mispred && (|(bm_r[i] & br_resolve));
    end
    for (int i = 0; i < DEPTH; i++) begin
      blocked_s[i] = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        blocked_s[i] = blocked_s[i] | (ready_s[j] & older_r[j][i]);
      end
    end
  end

  // Oldest ready entry and lowest free slot.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_idx_s   = '0;
    free_idx_s  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready_s[i] && !blocked_s[i]) begin
        sel_valid_s = 1'b1;
        sel_idx_s   = IW'(i);
      end else begin
        sel_valid_s = sel_valid_s;
      end
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_r[i]) begin
        free_idx_s = IW'(i);
      end else begin
        free_idx_s = free_idx_s;
      end
    end
  end

  // Fill merge for resident entries and for the packet being allocated.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      {mrg_pend_s[i], mrg_data_s[i]} = merge_fill(mshr_r[i], addr_r[i], pend_r[i], data_r[i],
                                                  fill_valid, fill_mshr, fill_data);
    end
    {in_pend_s, in_data_s} = merge_fill(in_mshr, in_addr, in_byte_mask, in_data,
                                        fill_valid, fill_mshr, fill_data);
  end

  // Next-cycle occupancy; a squash and a grant on one entry free it only once.
  always_comb begin
    cnt_nxt_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_nxt_s[i] = (valid_r[i] && !squash_s[i] && !(gnt_s && (sel_idx_s == IW'(i))))
                     || (alloc_s && (free_idx_s == IW'(i)));
      cnt_nxt_s      = cnt_nxt_s + CW'(valid_nxt_s[i]);
    end
  end

  // CDB presentation driven from registered state only.
  always_comb begin
    if (sel_valid_s) begin
      cdb_req  = 1'b1;
      cdb_dest = dest_r[sel_idx_s];
      cdb_data = format_result(data_r[sel_idx_s], addr_r[sel_idx_s][1:0], func_r[sel_idx_s]);
    end else begin
      cdb_req  = 1'b0;
      cdb_dest = '0;
      cdb_data = 32'd0;
    end
  end

  // Entry storage, age matrix and occupancy count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_r <= '0;
      count_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_r[i]  <= '0;
        bm_r[i]    <= '0;
        mshr_r[i]  <= '0;
        addr_r[i]  <= '0;
        func_r[i]  <= 3'd0;
        pend_r[i]  <= 4'd0;
        data_r[i]  <= 32'd0;
        older_r[i] <= '0;
      end
    end else begin
      valid_r <= valid_nxt_s;
      count_r <= cnt_nxt_s;
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_s && (free_idx_s == IW'(i))) begin
          dest_r[i]  <= in_dest;
          bm_r[i]    <= in_bm & ~br_resolve;
          mshr_r[i]  <= in_mshr;
          addr_r[i]  <= in_addr;
          func_r[i]  <= in_func;
          pend_r[i]  <= in_pend_s;
          data_r[i]  <= in_data_s;
          older_r[i] <= '0;
        end else begin
          bm_r[i]   <= bm_r[i] & ~br_resolve;
          pend_r[i] <= mrg_pend_s[i];
          data_r[i] <= mrg_data_s[i];
          if (alloc_s) begin
            older_r[i][free_idx_s] <= 1'b1;
          end
        end
      end
    end
  end

endmodule
